sprite_table_writer: RTL and testbench
======================================

Name: sprite_table_writer

Overview:
Producer end of the PPU sprite-table interface. Game-logic state machine writes two sprite entries into shadow registers through a valid/ready handshake. On commit request the block copies the shadow table atomically to the 64-bit `sprites` bus at the next vsync rising edge, so the PPU never samples a half-updated table mid-frame. It also auto-steps the 2-bit animation frame field of enabled sprites every FRAME_DIV frames.

Parameters:
X_MAX, 319, max world x in 4-px units (1280/4 - 1); larger writes saturate
Y_MAX, 192, max world y in 4-px units (PPU computes 770 - 4*y); larger writes saturate
FRAME_DIV, 8, vsync edges per animation frame step (>=1, width 8 bits)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
vsync  in  1  vsync from vga_controller, active-high
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_index  in  1  0 = sprite1 (sprites[63:32]), 1 = sprite2 (sprites[31:0])
wr_x  in  9  world x
wr_y  in  9  world y
wr_dir  in  1  facing bit (entry bit 7)
wr_anim  in  4  animation select (bits 6:3)
wr_frame  in  2  frame select (bits 2:1)
wr_alt  in  1  alternate palette (bit 0)
wr_anim_en  in  1  enable auto frame stepping for this entry
wr_commit  in  1  request commit of shadow table at next vsync edge
sprites  out  64  active sprite table to PPU
pending  out  1  commit requested, not yet done
commit_done  out  1  one-cycle pulse after commit
clamped  out  1  one-cycle pulse: accepted write had x or y saturated

Behaviour:
- Entry format: {x[8:0], y[8:0], 6'b0, dir, anim[3:0], frame[1:0], alt}. Bits 13:8 are always 0.
- Reset: sprites=0, both shadows=0, shadow/active anim_en=0, state IDLE, vsync_q=0, div counter=0, pending=0, commit_done=0, clamped=0.
- Reset takes effect asynchronously from any state. A pending commit is dropped.
- vsync edge: vedge = vsync & ~vsync_q, with vsync_q registered each cycle. If vsync is high on the first cycle after reset, that cycle counts as an edge.
- FSM states: IDLE, PENDING, COMMIT.
  - IDLE: wr_ready=1. An accepted write updates shadow[wr_index] and shadow_en[wr_index] at the clock edge. wr_commit=1 moves to PENDING. If a write and wr_commit occur in the same cycle, the write is accepted and included in the commit.
  - PENDING: wr_ready=0 and pending=1; wr_commit is ignored. On vedge: sprites <= {shadow0, shadow1}, active_en <= shadow_en, go to COMMIT.
  - COMMIT: wr_ready=0, commit_done=1 for exactly one cycle, then go to IDLE.
- Latency: commit lands on the same clock edge that samples vsync=1 with vsync_q=0. commit_done is high the following cycle.
- Saturation: x' = min(wr_x, X_MAX), y' = min(wr_y, Y_MAX). clamped=1 in the cycle after an accepted write where either value was saturated, else 0. Non-accepted writes never set clamped.
- Animation divider: 8-bit counter advances on every vedge in all states.
  - At count FRAME_DIV-1 it wraps to 0 and that edge is a tick.
  - On a tick, each active entry with active_en=1 gets frame <= frame+1, mod 4 (3 -> 0). Entries with active_en=0 are unchanged.
  - If a tick and a commit hit the same edge, the committed shadow value wins for all fields; no increment is applied that edge.
  - Auto-stepping never modifies the shadow registers.
- sprites changes only on vedge. It is stable between vsync edges, including across PPU hsync sampling.
- Writes to the same index overwrite; last accepted write before commit wins.

Test Plan:
- Reset, then write idx0 x=100,y=50,dir=1,anim=3,frame=2,alt=0 and commit; pulse vsync -> sprites[63:32]=0x320C809C on the vedge clock, sprites[31:0]=0, commit_done high 1 cycle later, pending 1 -> 0.
- Write idx1 with no wr_commit, toggle vsync 3 times -> sprites unchanged. Then commit, and during PENDING hold wr_valid=1 with different data -> wr_ready=0, write not taken, committed value is the pre-PENDING one.
- Write x=400, y=300 -> stored x=319, y=192, clamped pulses once. Write x=319, y=192 -> clamped stays 0.
- FRAME_DIV=2, idx0 anim_en=1 frame=3, committed -> after every 2nd vedge frame cycles 0,1,2,3. idx1 with anim_en=0 is unchanged.
- Tick coincident with commit of frame=1 -> frame=1 after that edge (no increment). Next tick -> frame=2.
- Assert reset while PENDING, then vsync edge -> sprites=0, pending=0, no commit_done, wr_ready=1 after reset release.

Source files
------------

// File: rtl/sprite_table_writer_if.sv
// sprite_table_writer_if
//   Write/commit bus between the game-logic producer and the sprite table
//   writer, plus the table and status signals the writer returns.
//   master : game logic  (drives wr_*, samples wr_ready and status)
//   slave  : the writer  (samples wr_*, drives wr_ready, sprites, status)
//   Signals:
//     wr_valid/wr_ready  handshake, write taken when both high
//     wr_index           0 = sprites[63:32], 1 = sprites[31:0]
//     wr_x, wr_y         world position in 4-px units
//     wr_dir, wr_anim, wr_frame, wr_alt, wr_anim_en  entry fields
//     wr_commit          request commit of the shadow table
//     sprites            active 64-bit table seen by the PPU
//     pending            commit requested, not yet done
//     commit_done        one-cycle pulse after a commit lands
//     clamped            one-cycle pulse after a saturated write
interface sprite_table_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_index;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic        wr_dir;
  logic [3:0]  wr_anim;
  logic [1:0]  wr_frame;
  logic        wr_alt;
  logic        wr_anim_en;
  logic        wr_commit;
  logic [63:0] sprites;
  logic        pending;
  logic        commit_done;
  logic        clamped;

  modport master (
    output wr_valid, wr_index, wr_x, wr_y, wr_dir, wr_anim, wr_frame,
           wr_alt, wr_anim_en, wr_commit,
    input  wr_ready, sprites, pending, commit_done, clamped
  );

  modport slave (
    input  wr_valid, wr_index, wr_x, wr_y, wr_dir, wr_anim, wr_frame,
           wr_alt, wr_anim_en, wr_commit,
    output wr_ready, sprites, pending, commit_done, clamped
  );
endinterface

// File: rtl/sprite_table_writer.sv
// sprite_table_writer
//   Producer end of the PPU sprite-table interface. Writes land in two
//   shadow entries; a commit request copies both shadows into the active
//   table in one step on the next vsync rising edge, so the PPU never sees
//   a half-updated table within a frame. Enabled active entries have their
//   2-bit frame field stepped every FRAME_DIV vsync edges.
//   Entry format: {x[8:0], y[8:0], 6'b0, dir, anim[3:0], frame[1:0], alt}
//   Ports:
//     clk_i    system clock
//     rst_i    asynchronous active-high reset
//     vsync_i  vsync from the VGA controller, active-high
//     bus      write/commit bus and table outputs (slave side)
module sprite_table_writer #(
  parameter int X_MAX     = 319,
  parameter int Y_MAX     = 192,
  parameter int FRAME_DIV = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vsync_i,
  sprite_table_writer_if.slave  bus
);

  localparam logic [8:0] X_LIM    = 9'(X_MAX);
  localparam logic [8:0] Y_LIM    = 9'(Y_MAX);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             vsync_q;
  logic [7:0]       div_q, div_d;
  logic [1:0][31:0] shadow_q, shadow_d;
  logic [1:0]       shadow_en_q, shadow_en_d;
  logic [1:0][31:0] active_q, active_d;
  logic [1:0]       active_en_q, active_en_d;
  logic             clamped_q, clamped_d;

  logic        wr_ready_c, pending_c, commit_done_c;
  logic        vedge, tick, commit_now, accept;
  logic [8:0]  x_sat, y_sat;
  logic        sat_hit;
  logic [31:0] wr_entry;

  // A high vsync on the first cycle after reset counts as an edge because
  // vsync_q resets low.
  assign vedge      = vsync_i & ~vsync_q;
  assign tick       = vedge && (div_q == DIV_LAST);
  assign commit_now = (state_q == PENDING) && vedge;
  assign accept     = bus.wr_valid && wr_ready_c;

  assign x_sat    = (bus.wr_x > X_LIM) ? X_LIM : bus.wr_x;
  assign y_sat    = (bus.wr_y > Y_LIM) ? Y_LIM : bus.wr_y;
  assign sat_hit  = (bus.wr_x > X_LIM) || (bus.wr_y > Y_LIM);
  assign wr_entry = {x_sat, y_sat, 6'b0, bus.wr_dir, bus.wr_anim,
                     bus.wr_frame, bus.wr_alt};

  // Handshake/commit FSM
  always_comb begin
    state_d       = state_q;
    wr_ready_c    = 1'b0;
    pending_c     = 1'b0;
    commit_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready_c = 1'b1;
        if (bus.wr_commit) state_d = PENDING;
      end
      PENDING: begin
        pending_c = 1'b1;
        if (vedge) state_d = COMMIT;
      end
      COMMIT: begin
        commit_done_c = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider runs on every vedge regardless of FSM state.
  always_comb begin
    div_d = div_q;
    if (vedge) div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
  end

  assign clamped_d = accept && sat_hit;

  // Per-entry shadow and active next-state. A commit overrides the frame
  // step on a coincident tick; stepping never touches the shadows.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic IDX = 1'(gi);
    logic        write_hit;
    logic [31:0] stepped;

    assign write_hit = accept && (bus.wr_index == IDX);
    assign stepped   = {active_q[gi][31:3], active_q[gi][2:1] + 2'd1,
                        active_q[gi][0]};

    assign shadow_d[gi]    = write_hit ? wr_entry : shadow_q[gi];
    assign shadow_en_d[gi] = write_hit ? bus.wr_anim_en : shadow_en_q[gi];

    assign active_d[gi]    = commit_now                    ? shadow_q[gi] :
                             (tick && active_en_q[gi])     ? stepped      :
                                                             active_q[gi];
    assign active_en_d[gi] = commit_now ? shadow_en_q[gi] : active_en_q[gi];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      div_q       <= 8'd0;
      shadow_q    <= '0;
      shadow_en_q <= '0;
      active_q    <= '0;
      active_en_q <= '0;
      clamped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_i;
      div_q       <= div_d;
      shadow_q    <= shadow_d;
      shadow_en_q <= shadow_en_d;
      active_q    <= active_d;
      active_en_q <= active_en_d;
      clamped_q   <= clamped_d;
    end
  end

  assign bus.wr_ready    = wr_ready_c;
  assign bus.pending     = pending_c;
  assign bus.commit_done = commit_done_c;
  assign bus.clamped     = clamped_q;
  assign bus.sprites     = {active_q[0], active_q[1]};

endmodule

// File: tb/tb_sprite_table_writer.sv
// Bench for sprite_table_writer (FRAME_DIV=2): directed vector table,
// animation/commit corner sequences, randomized traffic against a
// transaction-level reference model, and reset while a commit is pending.
module tb_sprite_table_writer;

  localparam int XM = 319;
  localparam int YM = 192;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;

  sprite_table_writer_if bus ();

  sprite_table_writer #(.X_MAX(XM), .Y_MAX(YM), .FRAME_DIV(FD)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .vsync_i (vsync),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: entries as records, commit state as flags.
  typedef struct {
    int x, y, dir, anim, frame, alt, en;
  } ent_t;

  ent_t m_sh[2];
  ent_t m_act[2];
  bit   m_pend, m_done, m_clamp, m_vprev;
  int   m_edges;

  function automatic logic [31:0] pack(ent_t e);
    logic [31:0] w;
    w = 32'(e.x) << 23;
    w = w | (32'(e.y) << 14);
    w = w | (32'(e.dir) << 7) | (32'(e.anim) << 3) | (32'(e.frame) << 1) | 32'(e.alt);
    return w;
  endfunction

  function automatic logic [63:0] m_sprites();
    return {pack(m_act[0]), pack(m_act[1])};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sh[i]  = '{0, 0, 0, 0, 0, 0, 0};
      m_act[i] = '{0, 0, 0, 0, 0, 0, 0};
    end
    m_pend = 0; m_done = 0; m_clamp = 0; m_vprev = 0; m_edges = 0;
  endfunction

  function automatic bit m_ready();
    return !m_pend && !m_done;
  endfunction

  // Apply one clock of the spec rules using the inputs present at the edge.
  function automatic void model_update();
    bit   rdy, edge_seen, acc, commit;
    ent_t e;
    rdy       = m_ready();
    edge_seen = vsync && !m_vprev;
    acc       = bus.wr_valid && rdy;
    commit    = m_pend && edge_seen;
    if (edge_seen) m_edges++;
    if (commit) begin
      m_act[0] = m_sh[0];
      m_act[1] = m_sh[1];
    end else if (edge_seen && (m_edges % FD == 0)) begin
      for (int i = 0; i < 2; i++)
        if (m_act[i].en != 0) m_act[i].frame = (m_act[i].frame + 1) % 4;
    end
    if (acc) begin
      e.x     = (int'(bus.wr_x) > XM) ? XM : int'(bus.wr_x);
      e.y     = (int'(bus.wr_y) > YM) ? YM : int'(bus.wr_y);
      e.dir   = int'(bus.wr_dir);
      e.anim  = int'(bus.wr_anim);
      e.frame = int'(bus.wr_frame);
      e.alt   = int'(bus.wr_alt);
      e.en    = int'(bus.wr_anim_en);
      m_sh[bus.wr_index] = e;
      m_clamp = (int'(bus.wr_x) > XM) || (int'(bus.wr_y) > YM);
    end else begin
      m_clamp = 0;
    end
    if (commit) m_pend = 0;
    else if (rdy && bus.wr_commit) m_pend = 1;
    m_done  = commit;
    m_vprev = vsync;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("sprites", bus.sprites, m_sprites());
    chk("pending", 64'(bus.pending), 64'(m_pend));
    chk("commit_done", 64'(bus.commit_done), 64'(m_done));
    chk("clamped", 64'(bus.clamped), 64'(m_clamp));
  endtask

  // Inputs already driven (at a negedge); run one clock and compare.
  task automatic step();
    #1;
    chk("wr_ready", 64'(bus.wr_ready), 64'(m_ready()));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit idx, input int x, input int y,
                       input int dir, input int anim, input int fr, input int alt,
                       input bit en, input bit cm, input bit vs);
    bus.wr_valid   = v;
    bus.wr_index   = idx;
    bus.wr_x       = 9'(x);
    bus.wr_y       = 9'(y);
    bus.wr_dir     = 1'(dir);
    bus.wr_anim    = 4'(anim);
    bus.wr_frame   = 2'(fr);
    bus.wr_alt     = 1'(alt);
    bus.wr_anim_en = en;
    bus.wr_commit  = cm;
    vsync          = vs;
  endtask

  task automatic idle(input bit vs);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, vs);
    step();
  endtask

  typedef struct {
    bit v; bit idx; int x, y, dir, anim, fr, alt; bit en, cm, vs;
    logic [63:0] e_spr; bit e_pend, e_done, e_clamp;
  } vec_t;

  function automatic vec_t mk(bit v, bit idx, int x, int y, int dir, int anim,
                              int fr, int alt, bit en, bit cm, bit vs,
                              logic [63:0] e_spr, bit e_pend, bit e_done, bit e_clamp);
    vec_t t;
    t.v = v; t.idx = idx; t.x = x; t.y = y; t.dir = dir; t.anim = anim;
    t.fr = fr; t.alt = alt; t.en = en; t.cm = cm; t.vs = vs;
    t.e_spr = e_spr; t.e_pend = e_pend; t.e_done = e_done; t.e_clamp = e_clamp;
    return t;
  endfunction

  vec_t tbl[14];
  int   exp_fr[8];

  initial begin
    logic [63:0] s1, s2;
    s1 = 64'h320C809C_00000000;
    s2 = 64'h9FB00000_9FB00003;
    //          v idx   x    y dir an fr al en cm vs   sprites pend done clamp
    tbl[0]  = mk(1, 0, 100,  50, 1, 3, 2, 0, 0, 1, 0,  64'h0, 1, 0, 0);
    tbl[1]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 1,  s1,    0, 1, 0);
    tbl[2]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 0,  s1,    0, 0, 0);
    tbl[3]  = mk(1, 0, 400, 300, 0, 0, 0, 0, 0, 0, 0,  s1,    0, 0, 1);
    tbl[4]  = mk(1, 1, 319, 192, 0, 0, 1, 1, 0, 0, 0,  s1,    0, 0, 0);
    tbl[5]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 1,  s1,    0, 0, 0);
    tbl[6]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 0,  s1,    0, 0, 0);
    tbl[7]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 1,  s1,    0, 0, 0);
    tbl[8]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 0,  s1,    0, 0, 0);
    tbl[9]  = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 1,  s1,    0, 0, 0);
    tbl[10] = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 1, 0,  s1,    1, 0, 0);
    tbl[11] = mk(1, 1,   5,   5, 1, 9, 3, 0, 1, 0, 0,  s1,    1, 0, 0);
    tbl[12] = mk(1, 1,   5,   5, 1, 9, 3, 0, 1, 0, 1,  s2,    0, 1, 0);
    tbl[13] = mk(0, 0,   0,   0, 0, 0, 0, 0, 0, 0, 0,  s2,    0, 0, 0);
    exp_fr = '{3, 0, 0, 1, 1, 2, 2, 3};

    // Reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_sprites", bus.sprites, 64'h0);
    chk("reset_pending", 64'(bus.pending), 64'h0);
    chk("reset_done", 64'(bus.commit_done), 64'h0);
    chk("reset_clamped", 64'(bus.clamped), 64'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].dir, tbl[i].anim,
            tbl[i].fr, tbl[i].alt, tbl[i].en, tbl[i].cm, tbl[i].vs);
      step();
      chk($sformatf("tbl%0d_sprites", i), bus.sprites, tbl[i].e_spr);
      chk($sformatf("tbl%0d_pending", i), 64'(bus.pending), 64'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_done", i), 64'(bus.commit_done), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d_clamped", i), 64'(bus.clamped), 64'(tbl[i].e_clamp));
    end

    // Animation: 5 edges so far, so the commit edge (6th) is also a tick.
    drive(1, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0); step();
    idle(1);
    chk("anim_commit_fr0", 64'(bus.sprites[34:33]), 64'd3);
    chk("anim_commit_fr1", 64'(bus.sprites[2:1]), 64'd2);
    for (int k = 0; k < 8; k++) begin
      idle(0);
      idle(1);
      chk($sformatf("anim_edge%0d_fr0", k + 7), 64'(bus.sprites[34:33]), 64'(exp_fr[k]));
      chk($sformatf("anim_edge%0d_fr1", k + 7), 64'(bus.sprites[2:1]), 64'd2);
    end
    // Edge 15 (no tick), then commit frame=1 on tick edge 16.
    idle(0); idle(1); idle(0);
    drive(1, 0, 7, 7, 0, 0, 1, 0, 1, 1, 0); step();
    idle(1);
    chk("coinc_tick_fr", 64'(bus.sprites[34:33]), 64'd1);
    idle(0); idle(1);
    chk("coinc_next_fr", 64'(bus.sprites[34:33]), 64'd1);
    idle(0); idle(1);
    chk("coinc_tick2_fr", 64'(bus.sprites[34:33]), 64'd2);
    chk("shadow_untouched_clamp", 64'(bus.clamped), 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0) ? ~vsync : vsync);
      step();
    end

    // Reset while a commit is pending
    idle(0); idle(0); idle(0);
    drive(1, 0, 33, 44, 1, 5, 1, 1, 1, 1, 0); step();
    chk("pre_reset_pending", 64'(bus.pending), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sprites", bus.sprites, 64'h0);
    chk("async_rst_pending", 64'(bus.pending), 64'h0);
    chk("async_rst_done", 64'(bus.commit_done), 64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("post_rst_sprites", bus.sprites, 64'h0);
    chk("post_rst_done", 64'(bus.commit_done), 64'h0);
    idle(0);
    chk("post_rst_ready", 64'(bus.wr_ready), 64'h1);
    chk("post_rst_pending", 64'(bus.pending), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
